// File: rtl/page_responder_pkg.sv
// Shared types and constants for the page-value request protocol.
// Page ids split into an owning-ant index (MSBs) and a local page index (LSBs).
package pr_pkg;
    localparam int ID_W    = 6;
    localparam int N       = 16;
    localparam int WIDTH   = 16;
    localparam int RESP_W  = WIDTH + ID_W;
    localparam int M       = 64;
    localparam int IDX_W   = $clog2(N);
    localparam int OWNER_W = ID_W - IDX_W;

    typedef logic [ID_W-1:0]    page_id_t;
    typedef logic [WIDTH-1:0]   val_t;
    typedef logic [RESP_W-1:0]  resp_t;
    typedef logic [OWNER_W-1:0] owner_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef struct packed {
        owner_t owner;
        idx_t   idx;
    } page_loc_t;

    function automatic page_loc_t split_page_id(input page_id_t id);
        page_loc_t loc;
        loc.owner = id[ID_W-1:IDX_W];
        loc.idx   = id[IDX_W-1:0];
        return loc;
    endfunction
endpackage

// File: rtl/page_responder_if.sv
// Query/response handshake bundle between the NoC and a page responder.
// The responder is the slave side; the NoC (or a bench) is the master.
interface page_responder_if;
    import pr_pkg::*;

    logic     query_valid;
    page_id_t query_id;
    logic     query_ready;
    logic     resp_valid;
    resp_t    resp_data;
    logic     resp_ready;

    modport master (
        output query_valid, query_id, resp_ready,
        input  query_ready, resp_valid, resp_data
    );

    modport slave (
        input  query_valid, query_id, resp_ready,
        output query_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/page_responder_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; full blocks push with no pop bypass.
// Shared with the NoC requester buffers.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which
    // entries are valid, and leaving it out keeps the array in plain RAM cells.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/page_responder.sv
// Serving end of the page-value protocol: queues page-id queries, looks up the
// live local value at pop time and returns {page id, value} to the NoC.
module page_responder
    import pr_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  owner_t               ant_id,
    input  logic [N*WIDTH-1:0]   node_vals,
    page_responder_if.slave      bus,
    output logic                 idle,
    output logic [15:0]          served_cnt,
    output logic [7:0]           misroute_cnt
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0] state;
    resp_t      resp_q;
    page_id_t   head;
    page_loc_t  head_loc;
    val_t       head_val;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       owned;
    logic       resp_valid;
    logic       handshake;

    sync_fifo #(
        .WIDTH (ID_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (bus.query_valid),
        .wr_data (bus.query_id),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign resp_valid = (state == ST_FULL);
    assign handshake  = resp_valid && bus.resp_ready;
    // The head leaves the FIFO whenever the output register is free or being drained.
    assign pop        = !fifo_empty && (!resp_valid || bus.resp_ready);
    assign head_loc   = split_page_id(head);
    assign owned      = (head_loc.owner == ant_id);
    assign head_val   = node_vals[int'(head_loc.idx)*WIDTH +: WIDTH];

    assign bus.query_ready = !fifo_full;
    assign bus.resp_valid  = resp_valid;
    assign bus.resp_data   = resp_q;
    assign idle            = fifo_empty && !resp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_EMPTY;
            resp_q       <= '0;
            served_cnt   <= '0;
            misroute_cnt <= '0;
        end else begin
            if (handshake) served_cnt <= served_cnt + 16'd1;

            if (pop) begin
                if (owned) begin
                    state  <= ST_FULL;
                    resp_q <= {head, head_val};
                end else begin
                    state <= ST_EMPTY;
                    if (misroute_cnt != 8'hFF) misroute_cnt <= misroute_cnt + 8'd1;
                end
            end else if (handshake) begin
                state <= ST_EMPTY;
            end
        end
    end
endmodule

// File: doc/page_responder.md
Name: page_responder

Overview:
- Serving end of the page-value request protocol between ants. Accepts 6-bit page-id queries arriving from the NoC for pages owned by this ant, and looks up the current rank value in the ant's local node-value array.
- Returns {page id, value} responses to the NoC. One instance per ant, sitting between the ant's value array and the NoC response router.

Parameters:
- N, 16, pages owned per ant (power of 2).
- WIDTH, 16, rank value width.
- ID_W, 6, global page id width (M=64 pages).
- DEPTH, 16, query FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ant_id  in  2  static index of the owning ant; compared against query_id[5:4].
- node_vals  in  N*WIDTH  live local value array; page k is at [k*WIDTH +: WIDTH].
- query_valid  in  1  NoC presents a query.
- query_id  in  ID_W  requested global page id.
- query_ready  out  1  FIFO can accept; equals !full.
- resp_valid  out  1  response register holds data.
- resp_data  out  WIDTH+ID_W  {page id[5:0], value[WIDTH-1:0]}.
- resp_ready  in  1  NoC consumes the response.
- idle  out  1  FIFO empty and !resp_valid; feeds the ant's sync logic.
- served_cnt  out  16  responses delivered, wraps at 2^16.
- misroute_cnt  out  8  queries dropped for wrong owner, saturates at 255.

Behaviour:
- Reset (async): FIFO pointers cleared; resp_valid=0; resp_data=0; served_cnt=0; misroute_cnt=0; query_ready=1; idle=1.
- Reset asserted mid-operation discards queued queries and any held response. No response is emitted after reset deasserts until a new query is accepted.
- Accept: a query is pushed on a clock edge where query_valid && query_ready. query_ready depends only on FIFO full, with no bypass, so a full FIFO blocks pushes even if a pop happens in the same cycle.
- FIFO: DEPTH entries of ID_W bits. Read and write pointers carry log2(DEPTH)+1 bits. Full when the MSBs differ and the low bits are equal; empty when the pointers are equal. Pointers wrap modulo 2*DEPTH.
- Simultaneous push and pop when neither full nor empty keeps the occupancy unchanged.
- Lookup/output stage has two states:
  - EMPTY (resp_valid=0): if the FIFO is non-empty, pop the head on the next edge.
  - FULL (resp_valid=1): hold resp_data stable until resp_ready.
  - On an edge with resp_valid && resp_ready: served_cnt increments. The stage either reloads from the FIFO head in the same edge (back-to-back, one response per cycle) or returns to EMPTY.
- Pop handling:
  - If head[5:4]==ant_id: resp_data <= {head, node_vals[head[3:0]*WIDTH +: WIDTH]} and resp_valid <= 1.
  - Else: the entry is discarded, misroute_cnt saturating-increments, and resp_valid stays/becomes 0. At most one misroute drop per cycle.
- The value is sampled at the pop edge, not at the accept edge, so the newest rank value is returned.
- Latency: a query accepted at edge E0 into an empty FIFO with an empty output stage shows resp_valid=1 after edge E1. The minimum accept-to-response latency is 1 cycle.
- resp_valid never drops without resp_ready; resp_data never changes while resp_valid && !resp_ready.
- idle is combinational from registered state.

Decomposition:
- Shared package pr_pkg holds:
  - constants ID_W=6, N=16, WIDTH=16, RESP_W=WIDTH+ID_W, M=64;
  - typedefs page_id_t [ID_W-1:0], val_t [WIDTH-1:0], resp_t [RESP_W-1:0];
  - the helper that splits a page id into owner and local index.
- One natural sub-module: sync_fifo (parameterised WIDTH/DEPTH, push/pop/full/empty). The noc requester buffers reuse it.

Test Plan:
1. Reset, ant_id=1, node_vals page 5 = 16'h0A3C, query_id=6'd21 with resp_ready=1 → resp_valid=1 one edge after acceptance, resp_data={6'd21,16'h0A3C}, served_cnt=1.
2. Query 6'd40 into ant_id=1 → no response, misroute_cnt=1, idle returns to 1. Then drive 300 misrouted queries → misroute_cnt stays at 255.
3. resp_ready=0 and push 17 queries for pages 16..31 (ant_id=1) → 16 held in the FIFO, 1 held in the output register. query_ready=0 after the FIFO fills; the 18th query is not accepted. Then release resp_ready=1 → 17 responses in order, one per cycle, served_cnt=17.
4. Page 3 changes from 16'h0001 to 16'h0002 while its query waits behind a stalled response → the delivered value is 16'h0002.
5. FIFO half-full with continuous push and pop for 40 cycles → occupancy constant, no loss or duplication. Pointer wrap past 2*DEPTH is exercised.
6. Assert reset while the FIFO holds 5 entries and resp_valid=1 → all outputs return to reset values immediately; no stale response after deassertion.
